// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared default operand width and 2-bit sequencer state encoding for the divider
package div_ctrl_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: E-stage divider bus (start/signed/opa/opb/annul/hold in, stall/ready/result out); master = execute stage, slave = divider
interface div_ctrl_if import div_ctrl_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               annul_i;
  logic               hold_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;
  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i, hold_i,
    input  stall_o, ready_o, result_o
  );
  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i, hold_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division step (rem_i, bit_i, den_i in; rem_o, q_o out); the sign of the trial difference selects restore or keep
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] den_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted, diff;
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, den_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: iterative DIV/DIVU sequencer (clk, rst, div_ctrl_if.slave bus) that stalls E while dividing and presents {hi, lo} in DONE
module div_ctrl import div_ctrl_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, den_q;
  logic               qneg_q, rneg_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   rem_d, quo_d, a_mag, b_mag;
  logic               qbit, a_neg, b_neg;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[WIDTH-1]),
    .den_i(den_q),
    .rem_o(rem_d),
    .q_o  (qbit)
  );
  assign quo_d = {quo_q[WIDTH-2:0], qbit};
  assign a_neg = bus.signed_i & bus.opa_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.opb_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.opa_i : bus.opa_i;
  assign b_mag = b_neg ? -bus.opb_i : bus.opb_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: if (bus.start_i && !bus.annul_i) begin
          rem_q   <= '0;
          quo_q   <= a_mag;
          den_q   <= b_mag;
          rneg_q  <= a_neg;
          qneg_q  <= a_neg ^ b_neg;
          cnt_q   <= '0;
          state_q <= (bus.opb_i == '0) ? DIV_ZERO : DIV_BUSY;
        end
        DIV_BUSY: if (bus.annul_i) begin
          state_q <= DIV_IDLE;
        end else begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DIV_DONE;
            result_q <= {rneg_q ? -rem_d : rem_d, qneg_q ? -quo_d : quo_d};
          end
        end
        DIV_ZERO: if (bus.annul_i) begin
          state_q <= DIV_IDLE;
        end else begin
          state_q  <= DIV_DONE;
          result_q <= {rneg_q ? -quo_q : quo_q, {WIDTH{1'b1}}};
        end
        default: state_q <= (bus.annul_i || !bus.hold_i) ? DIV_IDLE : DIV_DONE;
      endcase
    end
  end
  assign bus.stall_o  = ~rst & (state_q == DIV_IDLE ? bus.start_i & ~bus.annul_i
                                                     : state_q inside {DIV_BUSY, DIV_ZERO});
  assign bus.ready_o  = ~rst & (state_q == DIV_DONE) & ~bus.annul_i;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed self-checking bench for div_ctrl against an arithmetic reference model
module tb_div_ctrl;
  import div_ctrl_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  always #5 clk = ~clk;
  div_ctrl_if #(.WIDTH(W)) bus ();
  div_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, q, r;
    bit na, nb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? {32'b0, -a} : {32'b0, a};
    mb = nb ? {32'b0, -b} : {32'b0, b};
    q  = ma / mb;
    r  = ma % mb;
    return {na ? -r[31:0] : r[31:0], (na ^ nb) ? -q[31:0] : q[31:0]};
  endfunction
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold_n);
    int cyc;
    logic [63:0] exp;
    exp = model(sgn, a, b);
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = sgn; bus.opa_i = a; bus.opb_i = b;
    #1;
    cyc = 0;
    while (bus.stall_o && cyc < 100) begin
      cyc++;
      @(negedge clk); #1;
    end
    check({tag, " stall_cycles"}, 64'(cyc), (b == 0) ? 64'd2 : 64'd33);
    check({tag, " ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, " result"}, bus.result_o, exp);
    bus.hold_i  = hold_n > 0;
    bus.start_i = hold_n > 0;
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk); #1;
      check({tag, " hold_ready"}, 64'(bus.ready_o), 64'd1);
      check({tag, " hold_stall"}, 64'(bus.stall_o), 64'd0);
      check({tag, " hold_result"}, bus.result_o, exp);
      if (i == hold_n - 1) begin
        bus.hold_i  = 1'b0;
        bus.start_i = 1'b0;
      end
    end
    @(negedge clk); #1;
    check({tag, " release_ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " release_stall"}, 64'(bus.stall_o), 64'd0);
  endtask
  initial begin
    int seen_ready;
    logic [31:0] a, b;
    bit sgn;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.opa_i = '0; bus.opb_i = '0;
    bus.annul_i = 1'b0; bus.hold_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.start_i = 1'b1;
    #1;
    check("reset_stall_forced", 64'(bus.stall_o), 64'd0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.opa_i = 32'd9; bus.opb_i = 32'd3;
    #1;
    check("start_annul_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    #1;
    check("start_annul_idle", {62'd0, bus.stall_o, bus.ready_o}, 64'd0);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    check("divu_100_7 exact", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 0);
    run_div("div_zero_neg", 1'b1, 32'hFFFF_FF00, 32'd0, 0);
    run_div("hold3", 1'b0, 32'd1000, 32'd33, 3);
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opa_i = 32'd500; bus.opb_i = 32'd5;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    check("annul_busy_stall", 64'(bus.stall_o), 64'd1);
    @(negedge clk);
    bus.annul_i = 1'b0;
    #1;
    check("annul_release_stall", 64'(bus.stall_o), 64'd0);
    seen_ready = 0;
    for (int i = 0; i < 40; i++) begin
      seen_ready += int'(bus.ready_o);
      @(negedge clk); #1;
    end
    check("annul_never_ready", 64'(seen_ready), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b1; bus.opa_i = 32'd77; bus.opb_i = 32'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy_ready", 64'(bus.ready_o), 64'd0);
    check("rst_mid_busy_result", bus.result_o, 64'd0);
    check("rst_mid_busy_idle", 64'(bus.stall_o), 64'd0);
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), sgn, a, b, $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
